// File: rtl/helper_axis_checker_pkg.sv
// rtl/helper_axis_checker_pkg.sv - shared types and constants for the AXIS stream checker helpers
package helper_axis_checker_pkg;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE,
        STALL
    } checker_state_t;

    localparam int CHECK_COUNT_WIDTH = 32;

    // Fibonacci taps for x^16+x^14+x^13+x^11+1 in a right-shifting register
    localparam logic [15:0] LFSR16_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr16_next(input logic [15:0] value);
        return {^(value & LFSR16_TAPS), value[15:1]};
    endfunction

endpackage

// File: rtl/helper_lfsr16.sv
// rtl/helper_lfsr16.sv - 16-bit Fibonacci LFSR, advances on enable, loads seed on reset
module helper_lfsr16
    import helper_axis_checker_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    logic [15:0] value_q;
    logic [15:0] value_d;

    always_comb begin
        value_d = value_q;
        if (enable) begin
            value_d = lfsr16_next(value_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            value_q <= seed;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/helper_axis_checker.sv
// rtl/helper_axis_checker.sv - joins DUT and golden streams, compares beat pairs, reports done/pass/stall
module helper_axis_checker
    import helper_axis_checker_pkg::*;
#(
    parameter int          DATA_WIDTH     = 10,
    parameter int          EXPECTED_COUNT = 1024,
    parameter int          THROTTLE       = 0,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    parameter int          TIMEOUT        = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         dut_valid,
    input  logic [DATA_WIDTH-1:0]        dut_data,
    output logic                         dut_ready,
    input  logic                         ref_valid,
    input  logic [DATA_WIDTH-1:0]        ref_data,
    output logic                         ref_ready,
    output logic                         done,
    output logic                         pass,
    output logic [CHECK_COUNT_WIDTH-1:0] mismatch_count,
    output logic [CHECK_COUNT_WIDTH-1:0] first_mismatch_index,
    output logic [DATA_WIDTH-1:0]        first_mismatch_dut,
    output logic [DATA_WIDTH-1:0]        first_mismatch_ref,
    output logic                         overrun,
    output logic                         timeout
);

    localparam int              CW             = CHECK_COUNT_WIDTH;
    localparam logic [CW-1:0]   LAST_BEAT      = CW'(EXPECTED_COUNT - 1);
    localparam logic [CW-1:0]   IDLE_LIMIT     = CW'(TIMEOUT - 1);
    localparam logic [3:0]      THROTTLE_LEVEL = THROTTLE[3:0];

    logic [15:0]     lfsr;
    logic            lfsr_unused;
    logic            gate;
    logic            acc;

    checker_state_t  state_q, state_d;
    logic [CW-1:0]   beat_count_q, beat_count_d;
    logic [CW-1:0]   idle_count_q, idle_count_d;
    logic [CW-1:0]   mismatch_count_q, mismatch_count_d;
    logic [CW-1:0]   first_index_q, first_index_d;
    logic [DATA_WIDTH-1:0] first_dut_q, first_dut_d;
    logic [DATA_WIDTH-1:0] first_ref_q, first_ref_d;
    logic            cmp_valid_q, cmp_valid_d;
    logic [CW-1:0]   cmp_index_q, cmp_index_d;
    logic [DATA_WIDTH-1:0] cmp_dut_q, cmp_dut_d;
    logic [DATA_WIDTH-1:0] cmp_ref_q, cmp_ref_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            overrun_q, overrun_d;
    logic            timeout_q, timeout_d;

    helper_lfsr16 u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .seed   (LFSR_SEED),
        .value  (lfsr)
    );

    assign lfsr_unused = ^lfsr[15:4];
    assign gate        = (THROTTLE == 0) || (lfsr[3:0] >= THROTTLE_LEVEL);
    assign acc         = (state_q == RUN) && enable && gate && dut_valid && ref_valid;

    always_comb begin
        state_d          = state_q;
        beat_count_d     = beat_count_q;
        idle_count_d     = idle_count_q;
        mismatch_count_d = mismatch_count_q;
        first_index_d    = first_index_q;
        first_dut_d      = first_dut_q;
        first_ref_d      = first_ref_q;
        cmp_valid_d      = acc;
        cmp_index_d      = cmp_index_q;
        cmp_dut_d        = cmp_dut_q;
        cmp_ref_d        = cmp_ref_q;
        overrun_d        = overrun_q;

        if (acc) begin
            cmp_index_d  = beat_count_q;
            cmp_dut_d    = dut_data;
            cmp_ref_d    = ref_data;
            beat_count_d = beat_count_q + 1'b1;
        end

        // Commit the pair accepted last cycle; runs in every state so the final beat lands during DRAIN
        if (cmp_valid_q && (cmp_dut_q != cmp_ref_q)) begin
            if (mismatch_count_q == '0) begin
                first_index_d = cmp_index_q;
                first_dut_d   = cmp_dut_q;
                first_ref_d   = cmp_ref_q;
            end
            if (mismatch_count_q != {CW{1'b1}}) begin
                mismatch_count_d = mismatch_count_q + 1'b1;
            end
        end

        if (acc) begin
            idle_count_d = '0;
        end else if ((state_q == RUN) && enable) begin
            idle_count_d = idle_count_q + 1'b1;
        end

        if ((state_q == DONE) && dut_valid) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            RUN: begin
                if (acc && (beat_count_q == LAST_BEAT)) begin
                    state_d = DRAIN;
                end else if ((TIMEOUT != 0) && enable && !acc && (idle_count_q == IDLE_LIMIT)) begin
                    state_d = STALL;
                end
            end
            DRAIN:   state_d = DONE;
            default: state_d = state_q;
        endcase

        done_d    = (state_d == DONE);
        timeout_d = (state_d == STALL);
        pass_d    = done_d && (mismatch_count_d == '0) && !overrun_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q          <= RUN;
            beat_count_q     <= '0;
            idle_count_q     <= '0;
            mismatch_count_q <= '0;
            first_index_q    <= '0;
            first_dut_q      <= '0;
            first_ref_q      <= '0;
            cmp_valid_q      <= 1'b0;
            cmp_index_q      <= '0;
            cmp_dut_q        <= '0;
            cmp_ref_q        <= '0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            overrun_q        <= 1'b0;
            timeout_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            beat_count_q     <= beat_count_d;
            idle_count_q     <= idle_count_d;
            mismatch_count_q <= mismatch_count_d;
            first_index_q    <= first_index_d;
            first_dut_q      <= first_dut_d;
            first_ref_q      <= first_ref_d;
            cmp_valid_q      <= cmp_valid_d;
            cmp_index_q      <= cmp_index_d;
            cmp_dut_q        <= cmp_dut_d;
            cmp_ref_q        <= cmp_ref_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            overrun_q        <= overrun_d;
            timeout_q        <= timeout_d;
        end
    end

    assign dut_ready            = acc;
    assign ref_ready            = acc;
    assign done                 = done_q;
    assign pass                 = pass_q;
    assign mismatch_count       = mismatch_count_q;
    assign first_mismatch_index = first_index_q;
    assign first_mismatch_dut   = first_dut_q;
    assign first_mismatch_ref   = first_ref_q;
    assign overrun              = overrun_q;
    assign timeout              = timeout_q;

endmodule

// File: tb/tb_helper_axis_checker.sv
// tb/tb_helper_axis_checker.sv - model-checked bench for helper_axis_checker, two parameter sets
module tb_helper_axis_checker;

    localparam int DW  = 10;
    localparam int EC0 = 8;
    localparam int TH0 = 0;
    localparam int TO0 = 16;
    localparam int EC1 = 64;
    localparam int TH1 = 8;
    localparam int TO1 = 0;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int P_EC [2] = '{EC0, EC1};
    localparam int P_TH [2] = '{TH0, TH1};
    localparam int P_TO [2] = '{TO0, TO1};
    localparam int PH_RUN = 0, PH_DRAIN = 1, PH_DONE = 2, PH_STALL = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]          rst, en, dv, rv;
    logic [1:0][DW-1:0]  dd, rd;
    logic [1:0]          dr, rr, done_o, pass_o, ovr_o, to_o;
    logic [1:0][31:0]    mis_o, fidx_o;
    logic [1:0][DW-1:0]  fd_o, fr_o;

    helper_axis_checker #(.DATA_WIDTH(DW), .EXPECTED_COUNT(EC0), .THROTTLE(TH0),
                          .LFSR_SEED(SEED), .TIMEOUT(TO0)) u_dut0 (
        .clk(clk), .rst(rst[0]), .enable(en[0]),
        .dut_valid(dv[0]), .dut_data(dd[0]), .dut_ready(dr[0]),
        .ref_valid(rv[0]), .ref_data(rd[0]), .ref_ready(rr[0]),
        .done(done_o[0]), .pass(pass_o[0]), .mismatch_count(mis_o[0]),
        .first_mismatch_index(fidx_o[0]), .first_mismatch_dut(fd_o[0]),
        .first_mismatch_ref(fr_o[0]), .overrun(ovr_o[0]), .timeout(to_o[0]));

    helper_axis_checker #(.DATA_WIDTH(DW), .EXPECTED_COUNT(EC1), .THROTTLE(TH1),
                          .LFSR_SEED(SEED), .TIMEOUT(TO1)) u_dut1 (
        .clk(clk), .rst(rst[1]), .enable(en[1]),
        .dut_valid(dv[1]), .dut_data(dd[1]), .dut_ready(dr[1]),
        .ref_valid(rv[1]), .ref_data(rd[1]), .ref_ready(rr[1]),
        .done(done_o[1]), .pass(pass_o[1]), .mismatch_count(mis_o[1]),
        .first_mismatch_index(fidx_o[1]), .first_mismatch_dut(fd_o[1]),
        .first_mismatch_ref(fr_o[1]), .overrun(ovr_o[1]), .timeout(to_o[1]));

    int errors = 0;
    int checks = 0;
    logic mon_on = 1'b0;

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, i, act, exp);
        end
    endtask

    // Reference model: pairs accepted, pending compare, mismatch record, phase of the run
    logic [15:0]   m_lfsr [2];
    int            m_beats [2], m_idle [2], m_phase [2], m_pidx [2];
    logic          m_pend [2], m_ovr [2];
    logic [DW-1:0] m_pd [2], m_pr [2], m_fd [2], m_fr [2];
    logic [31:0]   m_mis [2], m_fidx [2];

    function automatic logic m_ready(input int i);
        return (m_phase[i] == PH_RUN) && en[i] && dv[i] && rv[i] &&
               ((P_TH[i] == 0) || (int'(m_lfsr[i][3:0]) >= P_TH[i]));
    endfunction

    always @(posedge clk) begin
        logic acc;
        int   old_phase;
        for (int i = 0; i < 2; i++) begin
            if (!rst[i]) begin
                m_lfsr[i] = SEED; m_beats[i] = 0; m_idle[i] = 0; m_phase[i] = PH_RUN;
                m_pidx[i] = 0; m_pend[i] = 1'b0; m_ovr[i] = 1'b0; m_pd[i] = '0; m_pr[i] = '0;
                m_fd[i] = '0; m_fr[i] = '0; m_mis[i] = '0; m_fidx[i] = '0;
            end else begin
                acc       = m_ready(i);
                old_phase = m_phase[i];
                if (m_pend[i] && (m_pd[i] != m_pr[i])) begin
                    if (m_mis[i] == 0) begin
                        m_fidx[i] = m_pidx[i]; m_fd[i] = m_pd[i]; m_fr[i] = m_pr[i];
                    end
                    if (m_mis[i] != 32'hFFFF_FFFF) m_mis[i] = m_mis[i] + 1;
                end
                m_pend[i] = acc;
                if (acc) begin
                    m_pd[i] = dd[i]; m_pr[i] = rd[i]; m_pidx[i] = m_beats[i];
                end
                if (old_phase == PH_DONE && dv[i]) m_ovr[i] = 1'b1;
                if (old_phase == PH_RUN) begin
                    if (acc && m_beats[i] == P_EC[i] - 1) m_phase[i] = PH_DRAIN;
                    else if (!acc && en[i] && P_TO[i] != 0 && m_idle[i] == P_TO[i] - 1) m_phase[i] = PH_STALL;
                end else if (old_phase == PH_DRAIN) begin
                    m_phase[i] = PH_DONE;
                end
                if (acc) m_idle[i] = 0;
                else if (old_phase == PH_RUN && en[i]) m_idle[i] = m_idle[i] + 1;
                if (acc) m_beats[i] = m_beats[i] + 1;
                if (en[i]) m_lfsr[i] = {m_lfsr[i][0] ^ m_lfsr[i][2] ^ m_lfsr[i][3] ^ m_lfsr[i][5], m_lfsr[i][15:1]};
            end
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            for (int i = 0; i < 2; i++) begin
                chk("dut_ready", i, 32'(dr[i]), 32'(m_ready(i)));
                chk("ref_ready", i, 32'(rr[i]), 32'(m_ready(i)));
                chk("done", i, 32'(done_o[i]), 32'(m_phase[i] == PH_DONE));
                chk("timeout", i, 32'(to_o[i]), 32'(m_phase[i] == PH_STALL));
                chk("pass", i, 32'(pass_o[i]), 32'(m_phase[i] == PH_DONE && m_mis[i] == 0 && !m_ovr[i]));
                chk("overrun", i, 32'(ovr_o[i]), 32'(m_ovr[i]));
                chk("mismatch_count", i, mis_o[i], m_mis[i]);
                chk("first_index", i, fidx_o[i], m_fidx[i]);
                chk("first_dut", i, 32'(fd_o[i]), 32'(m_fd[i]));
                chk("first_ref", i, 32'(fr_o[i]), 32'(m_fr[i]));
            end
        end
    end

    logic [DW-1:0] dq [2][64];
    logic [DW-1:0] rq [2][64];

    task automatic do_reset(input int i);
        rst[i] = 1'b0; dv[i] = 1'b0; rv[i] = 1'b0; en[i] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst[i] = 1'b1;
    endtask

    // mode 0: both valid, 1: ref valid every other cycle, 2: random valids/enable,
    // 3: like 0 but dut stays valid alone once nbeats are sent
    task automatic drive(input int i, input int ncyc, input int nbeats, input int mode, input logic en_gap,
                         output int xfers, output int first_x, output int last_x,
                         output int done_at, output int to_at, output int thr_bad);
        int sb;
        int k;
        sb = 0; xfers = 0; first_x = -1; last_x = -1; done_at = -1; to_at = -1; thr_bad = 0;
        for (int c = 0; c < ncyc; c++) begin
            k = (sb < 64) ? sb : 63;
            if (mode == 2) begin
                dv[i] = ($urandom_range(0, 3) != 0);
                rv[i] = ($urandom_range(0, 3) != 0);
                en[i] = ($urandom_range(0, 9) != 0);
            end else if (sb < nbeats) begin
                dv[i] = 1'b1;
                rv[i] = (mode == 1) ? ((c % 2) == 0) : 1'b1;
                en[i] = 1'b1;
            end else begin
                dv[i] = (mode == 3);
                rv[i] = 1'b0;
                en[i] = en_gap;
            end
            dd[i] = dq[i][k];
            rd[i] = rq[i][k];
            @(negedge clk);
            if (dr[i]) begin
                sb++; xfers++;
                if (first_x < 0) first_x = c;
                last_x = c;
                if (P_TH[i] != 0 && int'(m_lfsr[i][3:0]) < P_TH[i]) thr_bad++;
            end
            if (done_o[i] && done_at < 0) done_at = c;
            if (to_o[i] && to_at < 0) to_at = c;
            @(posedge clk); #1;
        end
    endtask

    int xf, fx, lx, dat, tat, tb_bad;
    int unused_r0 [6];
    int unused_r1 [6];

    initial begin
        rst = 2'b00; en = 2'b11; dv = 2'b00; rv = 2'b00; dd = '0; rd = '0;
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 64; k++) begin
                dq[i][k] = DW'(k);
                rq[i][k] = DW'(k);
            end
        @(posedge clk); #1;
        mon_on = 1'b1;
        @(posedge clk); #1;
        chk("rst_mismatch_count", 0, mis_o[0], 32'd0);
        chk("rst_done", 0, 32'(done_o[0]), 32'd0);
        rst[0] = 1'b1;

        // in-order matching stream
        drive(0, 12, 8, 0, 1'b1, xf, fx, lx, dat, tat, tb_bad);
        chk("t1_transfers", 0, xf, 8);
        chk("t1_first_xfer", 0, fx, 0);
        chk("t1_last_xfer", 0, lx, 7);
        chk("t1_done_latency", 0, dat - lx, 2);
        chk("t1_pass", 0, 32'(pass_o[0]), 32'd1);
        chk("t1_mismatch_count", 0, mis_o[0], 32'd0);

        // dut_valid after done
        dv[0] = 1'b1; rv[0] = 1'b1;
        @(negedge clk);
        chk("ovr_ready", 0, 32'(dr[0]), 32'd0);
        @(posedge clk); #1;
        chk("ovr_flag", 0, 32'(ovr_o[0]), 32'd1);
        chk("ovr_pass", 0, 32'(pass_o[0]), 32'd0);

        // two corrupted beats
        do_reset(0);
        dq[0][5] = 10'h3FF; dq[0][6] = 10'h02A;
        drive(0, 12, 8, 0, 1'b1, xf, fx, lx, dat, tat, tb_bad);
        chk("t2_mismatch_count", 0, mis_o[0], 32'd2);
        chk("t2_first_index", 0, fidx_o[0], 32'd5);
        chk("t2_first_dut", 0, 32'(fd_o[0]), 32'h3FF);
        chk("t2_first_ref", 0, 32'(fr_o[0]), 32'h005);
        chk("t2_pass", 0, 32'(pass_o[0]), 32'd0);
        chk("t2_done", 0, 32'(done_o[0]), 32'd1);

        rst[0] = 1'b0; dv[0] = 1'b0; rv[0] = 1'b0;
        @(posedge clk); #1;
        chk("rst_clears_count", 0, mis_o[0], 32'd0);
        chk("rst_clears_index", 0, fidx_o[0], 32'd0);
        chk("rst_clears_dut", 0, 32'(fd_o[0]), 32'd0);
        chk("rst_clears_done", 0, 32'(done_o[0]), 32'd0);
        rst[0] = 1'b1;

        // reset while the bad beat 5 is still in the compare stage
        drive(0, 6, 8, 0, 1'b1, xf, fx, lx, dat, tat, tb_bad);
        rst[0] = 1'b0; dv[0] = 1'b0; rv[0] = 1'b0;
        @(posedge clk); #1;
        rst[0] = 1'b1;
        @(posedge clk); #1;
        chk("inflight_discard", 0, mis_o[0], 32'd0);
        dq[0][5] = 10'd5; dq[0][6] = 10'd6;

        // ref valid on alternate cycles only
        do_reset(0);
        drive(0, 30, 8, 1, 1'b1, xf, fx, lx, dat, tat, tb_bad);
        chk("t4_transfers", 0, xf, 8);
        chk("t4_last_xfer", 0, lx, 14);
        chk("t4_pass", 0, 32'(pass_o[0]), 32'd1);

        // golden stream dries up after 3 beats
        do_reset(0);
        drive(0, 30, 3, 3, 1'b1, xf, fx, lx, dat, tat, tb_bad);
        chk("t5_last_xfer", 0, lx, 2);
        chk("t5_timeout_delay", 0, tat - lx, 17);
        chk("t5_timeout", 0, 32'(to_o[0]), 32'd1);
        chk("t5_done", 0, 32'(done_o[0]), 32'd0);

        do_reset(0);
        drive(0, 40, 3, 3, 1'b0, xf, fx, lx, dat, tat, tb_bad);
        chk("t5_en_low_no_stall", 0, tat, -1);
        chk("t5_en_low_timeout", 0, 32'(to_o[0]), 32'd0);

        // throttled instance: seed ACE1 -> 5670 -> AB38, first gate opening in cycle 2
        for (int k = 0; k < 64; k++) begin
            dq[1][k] = DW'($urandom);
            rq[1][k] = dq[1][k];
        end
        chk("lfsr_seed", 1, 32'(m_lfsr[1]), 32'h0000ACE1);
        rst[1] = 1'b1;
        drive(1, 600, 64, 0, 1'b1, xf, fx, lx, dat, tat, tb_bad);
        chk("t3_first_xfer", 1, fx, 2);
        chk("t3_transfers", 1, xf, 64);
        chk("t3_gate_violations", 1, tb_bad, 0);
        chk("t3_pass", 1, 32'(pass_o[1]), 32'd1);

        // random valids, enable and occasional corruption on both instances
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 64; k++) begin
                dq[i][k] = DW'($urandom);
                rq[i][k] = ($urandom_range(0, 5) == 0) ? (dq[i][k] ^ DW'(1 << $urandom_range(0, DW - 1))) : dq[i][k];
            end
        fork
            do_reset(0);
            do_reset(1);
        join
        fork
            drive(0, 300, 64, 2, 1'b1, unused_r0[0], unused_r0[1], unused_r0[2], unused_r0[3], unused_r0[4], unused_r0[5]);
            drive(1, 300, 64, 2, 1'b1, unused_r1[0], unused_r1[1], unused_r1[2], unused_r1[3], unused_r1[4], unused_r1[5]);
        join

        mon_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
